// File: rtl/decode_decompress.sv
// decode_decompress
//   Receive-side unpack + decompress. Accepts packed 16-bit word pairs and
//   unpacks them LSB-first into DD-bit coefficients. Each coefficient x is
//   decompressed to y = (x*3329 + 2^(DD-1)) >> DD, which is at most 3328.
//   Results are emitted two per output cycle.
//
// Parameter
//   DD          coefficient bit width; must be 4 or 10
//
// Ports
//   clk         rising-edge clock
//   reset       synchronous, active-high; clears all state
//   set         global enable; every register holds while low
//   readin      input pair valid
//   in_ready    buffer can take a pair (occupancy <= 32)
//   din1/din2   lower/upper packed words
//   dout1/dout2 even/odd coefficient, zero-extended 12-bit result
//   out_index   index of the current output pair
//   readout_ok  dout1/dout2/out_index valid (single-cycle)
//
// Build option
//   DECODE_DECOMPRESS_RAW_EN  bypass the arithmetic; dout = zero-extended x
module decode_decompress #(
  parameter int DD = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        set,
  input  logic        readin,
  output logic        in_ready,
  input  logic [15:0] din1,
  input  logic [15:0] din2,
  output logic [15:0] dout1,
  output logic [15:0] dout2,
  output logic [6:0]  out_index,
  output logic        readout_ok
);

  localparam int W2 = 2 * DD;
  localparam int PW = DD + 12;

  generate
    if (DD != 4 && DD != 10) begin : g_bad_dd
      $error("decode_decompress: DD must be 4 or 10");
    end
  endgenerate

  logic [63:0]    sr;
  logic [6:0]     cnt;
  logic [DD-1:0]  x0, x1;
  logic           valid_u;
  logic [PW-1:0]  p0, p1;
  logic           valid_m;

  logic           consume;
  logic           accept;
  logic [6:0]     base;
  logic [63:0]    sr_next;
  logic [6:0]     cnt_next;

  assign in_ready = (cnt <= 7'd32);

  // Consume and append can happen on the same edge: the new pair lands
  // just above whatever survives this cycle's shift.
  always_comb begin
    consume  = (cnt >= 7'(W2));
    accept   = readin && in_ready;
    base     = consume ? (cnt - 7'(W2)) : cnt;
    sr_next  = consume ? (sr >> W2) : sr;
    if (accept) begin
      sr_next = sr_next | ({32'b0, din2, din1} << base);
    end
    cnt_next = base + (accept ? 7'd32 : 7'd0);
  end

`ifndef DECODE_DECOMPRESS_RAW_EN
  localparam logic [PW-1:0] ROUND = PW'(1) << (DD - 1);
  logic [PW-1:0] r0, r1;

  // Product plus rounding never exceeds PW bits for DD = 4 or 10.
  always_comb begin
    r0 = p0 + ROUND;
    r1 = p1 + ROUND;
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      sr         <= '0;
      cnt        <= '0;
      x0         <= '0;
      x1         <= '0;
      valid_u    <= 1'b0;
      p0         <= '0;
      p1         <= '0;
      valid_m    <= 1'b0;
      dout1      <= '0;
      dout2      <= '0;
      readout_ok <= 1'b0;
      out_index  <= '0;
    end else if (set) begin
      sr  <= sr_next;
      cnt <= cnt_next;

      valid_u <= consume;
      if (consume) begin
        x0 <= sr[DD-1:0];
        x1 <= sr[W2-1:DD];
      end

      valid_m <= valid_u;
      if (valid_u) begin
`ifdef DECODE_DECOMPRESS_RAW_EN
        p0 <= PW'(x0);
        p1 <= PW'(x1);
`else
        p0 <= PW'(x0) * PW'(12'd3329);
        p1 <= PW'(x1) * PW'(12'd3329);
`endif
      end

      readout_ok <= valid_m;
      if (valid_m) begin
`ifdef DECODE_DECOMPRESS_RAW_EN
        dout1 <= 16'(p0);
        dout2 <= 16'(p1);
`else
        dout1 <= 16'(r0[PW-1:DD]);
        dout2 <= 16'(r1[PW-1:DD]);
`endif
      end

      if (readout_ok) begin
        out_index <= out_index + 7'd1;
      end
    end
  end

endmodule

// File: tb/tb_decode_decompress.sv
// tb_decode_decompress
//   Directed bench driving DD=4 and DD=10 instances from shared stimulus.
//   Outputs are captured at the falling edge whenever readout_ok is high
//   and set is high, i.e. when a consumer would take them.
module tb_decode_decompress;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        set = 1'b1;
  logic        readin = 1'b0;
  logic [15:0] din1 = '0;
  logic [15:0] din2 = '0;

  logic        in_ready4, in_ready10;
  logic [15:0] d1_4, d2_4, d1_10, d2_10;
  logic [6:0]  idx4, idx10;
  logic        ro4, ro10;

  int unsigned cyc = 0;
  int unsigned n_tests = 0;
  int unsigned n_fail = 0;

  typedef struct {
    int unsigned cyc;
    logic [6:0]  idx;
    logic [15:0] a;
    logic [15:0] b;
  } out_t;

  out_t q4[$];
  out_t q10[$];

`ifdef DECODE_DECOMPRESS_RAW_EN
  localparam int unsigned E_F4  = 15;
  localparam int unsigned E_3FF = 1023;
  localparam int unsigned E_512 = 512;
  localparam int unsigned E_1   = 1;
  int unsigned exp_t1[8] = '{0, 1, 2, 3, 4, 5, 6, 7};
`else
  localparam int unsigned E_F4  = 3121;
  localparam int unsigned E_3FF = 3326;
  localparam int unsigned E_512 = 1665;
  localparam int unsigned E_1   = 3;
  int unsigned exp_t1[8] = '{0, 208, 416, 624, 832, 1040, 1248, 1456};
`endif

  decode_decompress #(.DD(4)) u_dut4 (
    .clk(clk), .reset(reset), .set(set), .readin(readin),
    .in_ready(in_ready4), .din1(din1), .din2(din2),
    .dout1(d1_4), .dout2(d2_4), .out_index(idx4), .readout_ok(ro4)
  );

  decode_decompress #(.DD(10)) u_dut10 (
    .clk(clk), .reset(reset), .set(set), .readin(readin),
    .in_ready(in_ready10), .din1(din1), .din2(din2),
    .dout1(d1_10), .dout2(d2_10), .out_index(idx10), .readout_ok(ro10)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (set && ro4)  q4.push_back('{cyc, idx4, d1_4, d2_4});
    if (set && ro10) q10.push_back('{cyc, idx10, d1_10, d2_10});
  end

  function automatic int unsigned decomp(input int unsigned x, input int unsigned dd);
`ifdef DECODE_DECOMPRESS_RAW_EN
    return x + 0 * dd;
`else
    return (x * 3329 + (1 << (dd - 1))) >> dd;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_tests++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    readin = 1'b0;
    set    = 1'b1;
    tick();
    reset = 1'b0;
    q4.delete();
    q10.delete();
  endtask

  // Presents a pair and holds it until accepted; acc is the accepting edge.
  task automatic push(input logic [15:0] a, input logic [15:0] b, input bit dd10,
                      output int unsigned acc);
    int unsigned k = 0;
    din1   = a;
    din2   = b;
    readin = 1'b1;
    while (!(dd10 ? in_ready10 : in_ready4) && k < 50) begin
      tick();
      k++;
    end
    if (!(dd10 ? in_ready10 : in_ready4)) check("push_timeout", 0, 1);
    tick();
    acc    = cyc;
    readin = 1'b0;
  endtask

  logic [15:0]   fr1[80];
  logic [15:0]   fr2[80];
  logic [2559:0] stream;

  initial begin
    int unsigned acc, acc2, k, guard;

    // ---- reset state
    do_reset();
    check("rst_ro4", ro4, 0);
    check("rst_idx4", idx4, 0);
    check("rst_rdy4", in_ready4, 1);
    check("rst_d1_4", d1_4, 0);
    check("rst_d2_4", d2_4, 0);
    check("rst_ro10", ro10, 0);
    check("rst_rdy10", in_ready10, 1);

    // ---- DD=4 single pair, nibbles 0..7
    push(16'h3210, 16'h7654, 1'b0, acc);
    check("t1_rdy_after", in_ready4, 1);
    repeat (8) tick();
    check("t1_count", q4.size(), 4);
    for (int i = 0; i < 4 && i < q4.size(); i++) begin
      check($sformatf("t1_cyc%0d", i), q4[i].cyc, acc + 3 + i);
      check($sformatf("t1_idx%0d", i), q4[i].idx, i);
      check($sformatf("t1_d1_%0d", i), q4[i].a, exp_t1[2*i]);
      check($sformatf("t1_d2_%0d", i), q4[i].b, exp_t1[2*i+1]);
    end

    // ---- DD=4 two all-ones pairs back-to-back; buffer fills past 32
    q4.delete();
    push(16'hFFFF, 16'hFFFF, 1'b0, acc);
    push(16'hFFFF, 16'hFFFF, 1'b0, acc2);
    check("t2_b2b", acc2, acc + 1);
    check("t2_rdy_full", in_ready4, 0);
    repeat (14) tick();
    check("t2_count", q4.size(), 8);
    for (int i = 0; i < 8 && i < q4.size(); i++) begin
      check($sformatf("t2_cyc%0d", i), q4[i].cyc, acc + 3 + i);
      check($sformatf("t2_idx%0d", i), q4[i].idx, 4 + i);
      check($sformatf("t2_d1_%0d", i), q4[i].a, E_F4);
      check($sformatf("t2_d2_%0d", i), q4[i].b, E_F4);
    end

    // ---- DD=4 all-ones pair with set toggling every other cycle
    q4.delete();
    din1 = 16'hFFFF; din2 = 16'hFFFF; readin = 1'b1; set = 1'b1;
    tick();
    acc = cyc;
    readin = 1'b0;
    for (int i = 0; i < 20; i++) begin
      set = ~set;
      tick();
    end
    set = 1'b1;
    repeat (4) tick();
    check("t3_count", q4.size(), 4);
    for (int i = 0; i < 4 && i < q4.size(); i++) begin
      check($sformatf("t3_cyc%0d", i), q4[i].cyc, acc + 7 + 2 * i);
      check($sformatf("t3_idx%0d", i), q4[i].idx, 12 + i);
      check($sformatf("t3_d1_%0d", i), q4[i].a, E_F4);
      check($sformatf("t3_d2_%0d", i), q4[i].b, E_F4);
    end

    // ---- DD=10 partial coefficients carried across pairs
    do_reset();
    push(16'hFFFF, 16'h000F, 1'b1, acc);
    repeat (6) tick();
    check("t4_count1", q10.size(), 1);
    if (q10.size() >= 1) begin
      check("t4_cyc0", q10[0].cyc, acc + 3);
      check("t4_idx0", q10[0].idx, 0);
      check("t4_d1_0", q10[0].a, E_3FF);
      check("t4_d2_0", q10[0].b, E_3FF);
    end
    push(16'h0000, 16'h0000, 1'b1, acc2);
    repeat (6) tick();
    check("t4_count3", q10.size(), 3);
    for (int i = 1; i < 3 && i < q10.size(); i++) begin
      check($sformatf("t4_cyc%0d", i), q10[i].cyc, acc2 + 2 + i);
      check($sformatf("t4_idx%0d", i), q10[i].idx, i);
      check($sformatf("t4_d1_%0d", i), q10[i].a, 0);
      check($sformatf("t4_d2_%0d", i), q10[i].b, 0);
    end

    // ---- DD=10 x0=512, x1=1
    do_reset();
    push(16'h0600, 16'h0000, 1'b1, acc);
    repeat (6) tick();
    check("t5_count", q10.size(), 1);
    if (q10.size() >= 1) begin
      check("t5_d1", q10[0].a, E_512);
      check("t5_d2", q10[0].b, E_1);
    end

    // ---- DD=10 full frame, readin held high
    do_reset();
    for (int i = 0; i < 80; i++) begin
      fr1[i] = 16'($urandom);
      fr2[i] = 16'($urandom);
      stream[i*32 +: 32] = {fr2[i], fr1[i]};
    end
    k = 0;
    guard = 0;
    while (k < 80 && guard < 400) begin
      din1 = fr1[k];
      din2 = fr2[k];
      readin = 1'b1;
      if (in_ready10) k++;
      tick();
      guard++;
    end
    readin = 1'b0;
    check("t6_pairs", k, 80);
    repeat (10) tick();
    check("t6_count", q10.size(), 128);
    for (int i = 0; i < 128 && i < q10.size(); i++) begin
      check($sformatf("t6_idx%0d", i), q10[i].idx, i);
      check($sformatf("t6_d1_%0d", i), q10[i].a, decomp(32'(stream[(2*i)*10 +: 10]), 10));
      check($sformatf("t6_d2_%0d", i), q10[i].b, decomp(32'(stream[(2*i+1)*10 +: 10]), 10));
    end
    check("t6_wrap", idx10, 0);
    check("t6_idle", ro10, 0);

    // ---- reset mid-stream with pairs in flight
    do_reset();
    push(16'h1234, 16'h5678, 1'b1, acc);
    push(16'h9ABC, 16'hDEF0, 1'b1, acc);
    push(16'h1111, 16'h2222, 1'b1, acc);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    q10.delete();
    check("t7_ro", ro10, 0);
    check("t7_idx", idx10, 0);
    check("t7_rdy", in_ready10, 1);
    repeat (8) tick();
    check("t7_quiet", q10.size(), 0);
    push(16'hFFFF, 16'h000F, 1'b1, acc);
    repeat (6) tick();
    check("t7_count", q10.size(), 1);
    if (q10.size() >= 1) begin
      check("t7_cyc0", q10[0].cyc, acc + 3);
      check("t7_idx0", q10[0].idx, 0);
      check("t7_d1", q10[0].a, E_3FF);
      check("t7_d2", q10[0].b, E_3FF);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
